// File: rtl/binary_gray_enc_if.sv
// rtl/binary_gray_enc_if.sv - stream bundle for the binary-to-Gray encoder
`timescale 1ns/1ps
interface binary_gray_enc_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] bin_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] xfer_count;

    // Producer/consumer side that drives binary words and accepts Gray words
    modport master (
        output bin_in, in_valid, out_ready,
        input  in_ready, gray_out, out_valid, xfer_count
    );

    // Encoder side
    modport slave (
        input  bin_in, in_valid, out_ready,
        output in_ready, gray_out, out_valid, xfer_count
    );
endinterface

// File: rtl/binary_gray_enc.sv
// rtl/binary_gray_enc.sv - streaming binary-to-Gray encoder with 2-entry skid buffer
`timescale 1ns/1ps
module binary_gray_enc #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    binary_gray_enc_if.slave bus
);
    // Occupancy of the main output register plus the skid register
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] main_q,      main_d;
    logic [WIDTH-1:0] skid_q,      skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] enc;

    // Handshake decode, encoding and next-state / datapath selection
    always_comb begin
        accept      = bus.in_valid & in_ready_q;
        drain       = out_valid_q & bus.out_ready;
        enc         = bus.bin_in ^ (bus.bin_in >> 1);
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = enc;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept) begin
                    if (drain) begin
                        // Main register drains and reloads in the same cycle
                        main_d = enc;
                    end else begin
                        skid_d  = enc;
                        state_d = ST_FULL;
                    end
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can move state
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Ready/valid are registered from the next occupancy, so in_ready never
        // sees out_ready combinationally
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, drain};
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.gray_out   = main_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_binary_gray_enc.sv
// tb/tb_binary_gray_enc.sv - scoreboard bench for binary_gray_enc
`timescale 1ns/1ps
module tb_binary_gray_enc;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    binary_gray_enc_if #(.WIDTH(W), .CNT_W(8)) if1 ();
    binary_gray_enc_if #(.WIDTH(W), .CNT_W(2)) if2 ();

    assign if2.bin_in    = if1.bin_in;
    assign if2.in_valid  = if1.in_valid;
    assign if2.out_ready = if1.out_ready;

    binary_gray_enc #(.WIDTH(W), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    binary_gray_enc #(.WIDTH(W), .CNT_W(2)) u_dut_w2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] sb[$];
    int exp_cnt = 0;
    logic [W-1:0] mon_b;
    int exp_wrap[5] = '{1, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] gray_of(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W-1; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    function automatic logic [W-1:0] bin_of(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, between input changes
    always @(negedge clk) begin
        if (!rst) begin
            if (if1.out_valid && if1.out_ready) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_b = sb.pop_front();
                    chk("sb_gray", 32'(if1.gray_out), 32'(gray_of(mon_b)));
                    chk("sb_roundtrip", 32'(bin_of(if1.gray_out)), 32'(mon_b));
                end
                chk("xfer_count", 32'(if1.xfer_count), 32'(exp_cnt[7:0]));
                chk("xfer_count_w2", 32'(if2.xfer_count), 32'(exp_cnt[1:0]));
                exp_cnt++;
            end
            if (if1.in_valid && if1.in_ready) sb.push_back(if1.bin_in);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        if1.bin_in    = '0;
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("init_out_valid", 32'(if1.out_valid), 0);
        chk("init_in_ready", 32'(if1.in_ready), 1);
        chk("init_gray", 32'(if1.gray_out), 0);
        chk("init_count", 32'(if1.xfer_count), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single word
        if1.bin_in = 4'd5; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        chk("single_gray", 32'(if1.gray_out), 32'b0111);
        chk("single_valid", 32'(if1.out_valid), 1);
        @(posedge clk); #1;
        chk("single_count", 32'(if1.xfer_count), 1);
        chk("single_drained", 32'(if1.out_valid), 0);

        // Back-to-back sweep, no bubbles
        for (int i = 0; i < 16; i++) begin
            if1.bin_in = 4'(i); if1.in_valid = 1'b1;
            @(posedge clk); #1;
            chk("sweep_valid", 32'(if1.out_valid), 1);
            chk("sweep_ready", 32'(if1.in_ready), 1);
            chk("sweep_gray", 32'(if1.gray_out), 32'(gray_of(4'(i))));
        end
        if1.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("sweep_count", 32'(if1.xfer_count), 17);

        // Backpressure
        if1.out_ready = 1'b0;
        if1.bin_in = 4'd2; if1.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready1", 32'(if1.in_ready), 1);
        if1.bin_in = 4'd3;
        @(posedge clk); #1;
        chk("bp_ready2", 32'(if1.in_ready), 0);
        chk("bp_gray2", 32'(if1.gray_out), 32'b0011);
        if1.bin_in = 4'd4;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_gray", 32'(if1.gray_out), 32'b0011);
            chk("bp_hold_valid", 32'(if1.out_valid), 1);
            chk("bp_hold_ready", 32'(if1.in_ready), 0);
        end
        if1.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_gray1", 32'(if1.gray_out), 32'b0010);
        chk("bp_rel_ready", 32'(if1.in_ready), 1);
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        chk("bp_rel_gray2", 32'(if1.gray_out), 32'b0110);
        @(posedge clk); #1;
        chk("bp_done", 32'(if1.out_valid), 0);

        // Asynchronous reset with two words buffered
        if1.out_ready = 1'b0;
        if1.bin_in = 4'd9; if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.bin_in = 4'd10;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        chk("pre_rst_count", 32'(if1.xfer_count), 20);
        chk("pre_rst_full", 32'(if1.in_ready), 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(if1.out_valid), 0);
        chk("rst_gray", 32'(if1.gray_out), 0);
        chk("rst_in_ready", 32'(if1.in_ready), 1);
        chk("rst_count", 32'(if1.xfer_count), 0);
        chk("rst_count_w2", 32'(if2.xfer_count), 0);
        sb.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Counter wrap on the CNT_W=2 instance
        if1.out_ready = 1'b1;
        if1.bin_in = 4'd0; if1.in_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            if (k < 5) if1.bin_in = 4'(k);
            else if1.in_valid = 1'b0;
            @(posedge clk); #1;
            chk("wrap_count", 32'(if2.xfer_count), 32'(exp_wrap[k-1]));
        end

        // Random valid/ready round trip over all values, twice
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 16; v++) begin
                automatic bit sent = 1'b0;
                automatic int tries = 0;
                if1.bin_in = 4'(v);
                while (!sent && tries < 200) begin
                    automatic bit acc;
                    if1.in_valid  = ($urandom_range(0, 3) != 0);
                    if1.out_ready = $urandom_range(0, 1) != 0;
                    acc = if1.in_valid && if1.in_ready;
                    @(posedge clk); #1;
                    if (acc) sent = 1'b1;
                    tries++;
                end
                chk("rand_accepted", 32'(sent), 1);
            end
        end
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(sb.size()), 0);
        chk("final_idle", 32'(if1.out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
